// File: rtl/pulse_qualifier.sv
// pulse_qualifier: debounces a raw detector input into a qualified level.
//   The input must be sampled high for ON_CYCLES consecutive edges before
//   out asserts. After out drops, a holdoff of OFF_CYCLES cycles ignores the
//   input. A saturating counter records how many times ACTIVE was entered.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   res        - synchronous active-high reset
//   in         - raw detector input
//   clr        - synchronous clear of evt_cnt only
//   out        - qualified level, high while ACTIVE
//   rise_pulse - one-cycle flag on the first cycle of ACTIVE
//   fall_pulse - one-cycle flag on the first cycle of HOLD
//   busy       - high whenever the FSM is not IDLE
//   evt_cnt    - saturating count of ACTIVE entries
module pulse_qualifier #(
  parameter int unsigned ON_CYCLES  = 1,
  parameter int unsigned OFF_CYCLES = 1,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned EVT_W      = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in,
  input  logic             clr,
  output logic             out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StQual   = 2'b01,
    StActive = 2'b10,
    StHold   = 2'b11
  } state_e;

  // One extra bit so cnt+1 cannot wrap before it is compared against ON_CYCLES.
  localparam logic [CNT_W:0]   OnTarget = (CNT_W+1)'(ON_CYCLES);
  localparam logic [CNT_W-1:0] OffLast  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [EVT_W-1:0] EvtMax   = {EVT_W{1'b1}};

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [EVT_W-1:0]   evt_cnt_q;
  logic               rise_q;
  logic               fall_q;
  logic [CNT_W:0]     cnt_inc;
  logic               enter_active;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    enter_active = 1'b0;
    if (in) begin
      if (state_q == StIdle && ON_CYCLES == 1) begin
        enter_active = 1'b1;
      end else if (state_q == StQual && cnt_inc == OnTarget) begin
        enter_active = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      evt_cnt_q <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;

      // clr wins over a coincident ACTIVE entry.
      if (clr) begin
        evt_cnt_q <= '0;
      end else if (enter_active && evt_cnt_q != EvtMax) begin
        evt_cnt_q <= evt_cnt_q + EVT_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (in) begin
            if (enter_active) begin
              state_q <= StActive;
              cnt_q   <= '0;
              rise_q  <= 1'b1;
            end else begin
              state_q <= StQual;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        StQual: begin
          if (!in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (enter_active) begin
            state_q <= StActive;
            cnt_q   <= '0;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        StActive: begin
          if (!in) begin
            state_q <= StHold;
            cnt_q   <= '0;
            fall_q  <= 1'b1;
          end
        end
        StHold: begin
          // Input is ignored for the whole holdoff.
          if (cnt_q == OffLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out        = (state_q == StActive);
  assign busy       = (state_q != StIdle);
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign evt_cnt    = evt_cnt_q;

endmodule

// File: tb/tb_pulse_qualifier.sv
// Directed bench for pulse_qualifier: instance a uses ON=3/OFF=2/EVT_W=8,
// instance b uses ON=1/OFF=1/EVT_W=2 for legacy and saturation behaviour.
module tb_pulse_qualifier;

  logic       clk;
  logic       res_a, in_a, clr_a;
  logic       out_a, rise_a, fall_a, busy_a;
  logic [7:0] evt_a;
  logic       res_b, in_b, clr_b;
  logic       out_b, rise_b, fall_b, busy_b;
  logic [1:0] evt_b;

  int n_chk  = 0;
  int n_pass = 0;

  pulse_qualifier #(
    .ON_CYCLES (3),
    .OFF_CYCLES(2),
    .CNT_W     (4),
    .EVT_W     (8)
  ) u_a (
    .clk       (clk),
    .res       (res_a),
    .in        (in_a),
    .clr       (clr_a),
    .out       (out_a),
    .rise_pulse(rise_a),
    .fall_pulse(fall_a),
    .busy      (busy_a),
    .evt_cnt   (evt_a)
  );

  pulse_qualifier #(
    .ON_CYCLES (1),
    .OFF_CYCLES(1),
    .CNT_W     (4),
    .EVT_W     (2)
  ) u_b (
    .clk       (clk),
    .res       (res_b),
    .in        (in_b),
    .clr       (clr_b),
    .out       (out_b),
    .rise_pulse(rise_b),
    .fall_pulse(fall_b),
    .busy      (busy_b),
    .evt_cnt   (evt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    res_a = 1'b1; in_a = 1'b1; clr_a = 1'b0;
    res_b = 1'b1; in_b = 1'b0; clr_b = 1'b0;

    // Reset with in high.
    tick();
    chk("rst_out", {31'd0, out_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_evt", {24'd0, evt_a}, 0);
    chk("rst_rise", {31'd0, rise_a}, 0);
    chk("rst_fall", {31'd0, fall_a}, 0);
    res_a = 1'b0; res_b = 1'b0;

    // Glitch: two high samples then low.
    in_a = 1'b1;
    tick();
    chk("gl_busy1", {31'd0, busy_a}, 1);
    tick();
    chk("gl_out2", {31'd0, out_a}, 0);
    in_a = 1'b0;
    tick();
    chk("gl_busy3", {31'd0, busy_a}, 0);
    chk("gl_out3", {31'd0, out_a}, 0);
    chk("gl_evt", {24'd0, evt_a}, 0);

    // Qualify: three high samples.
    in_a = 1'b1;
    tick();
    chk("q_busy1", {31'd0, busy_a}, 1);
    chk("q_out1", {31'd0, out_a}, 0);
    tick();
    chk("q_out2", {31'd0, out_a}, 0);
    tick();
    chk("q_out3", {31'd0, out_a}, 1);
    chk("q_rise3", {31'd0, rise_a}, 1);
    chk("q_evt3", {24'd0, evt_a}, 1);
    tick();
    chk("q_out4", {31'd0, out_a}, 1);
    chk("q_rise4", {31'd0, rise_a}, 0);

    // Holdoff: one low sample, then in high is ignored for two HOLD cycles.
    in_a = 1'b0;
    tick();
    chk("h_out1", {31'd0, out_a}, 0);
    chk("h_fall1", {31'd0, fall_a}, 1);
    chk("h_busy1", {31'd0, busy_a}, 1);
    in_a = 1'b1;
    tick();
    chk("h_fall2", {31'd0, fall_a}, 0);
    chk("h_busy2", {31'd0, busy_a}, 1);
    chk("h_out2", {31'd0, out_a}, 0);
    tick();
    chk("h_idle", {31'd0, busy_a}, 0);
    tick();
    chk("rq_busy1", {31'd0, busy_a}, 1);
    chk("rq_out1", {31'd0, out_a}, 0);
    tick();
    chk("rq_out2", {31'd0, out_a}, 0);
    tick();
    chk("rq_out3", {31'd0, out_a}, 1);
    chk("rq_evt", {24'd0, evt_a}, 2);

    // Reset mid-HOLD.
    in_a = 1'b0;
    tick();
    chk("mh_busy", {31'd0, busy_a}, 1);
    res_a = 1'b1;
    tick();
    chk("mh_rst_busy", {31'd0, busy_a}, 0);
    chk("mh_rst_evt", {24'd0, evt_a}, 0);
    chk("mh_rst_fall", {31'd0, fall_a}, 0);
    res_a = 1'b0;

    // Reset mid-QUAL.
    in_a = 1'b1;
    tick();
    chk("mq_busy", {31'd0, busy_a}, 1);
    res_a = 1'b1;
    tick();
    chk("mq_rst_busy", {31'd0, busy_a}, 0);
    res_a = 1'b0;
    tick();
    tick();
    chk("mq_out_after2", {31'd0, out_a}, 0);

    // Legacy sequence on instance b: in = 0,1,1,0,1,0 -> out = 0,1,1,0,0,0.
    in_b = 1'b0; tick(); chk("lg0", {31'd0, out_b}, 0);
    in_b = 1'b1; tick(); chk("lg1", {31'd0, out_b}, 1);
    in_b = 1'b1; tick(); chk("lg2", {31'd0, out_b}, 1);
    in_b = 1'b0; tick(); chk("lg3", {31'd0, out_b}, 0);
    chk("lg3_fall", {31'd0, fall_b}, 1);
    in_b = 1'b1; tick(); chk("lg4", {31'd0, out_b}, 0);
    in_b = 1'b0; tick(); chk("lg5", {31'd0, out_b}, 0);
    chk("lg5_busy", {31'd0, busy_b}, 0);

    // Saturation on 2-bit counter: entries 1..5 give 1,2,3,3,3.
    res_b = 1'b1;
    tick();
    res_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_b = 1'b1;
      tick();
      chk("sat_evt", {30'd0, evt_b}, (i > 3) ? 3 : i);
      in_b = 1'b0;
      tick();
      tick();
    end

    // Clear coinciding with the 6th entry wins.
    in_b  = 1'b1;
    clr_b = 1'b1;
    tick();
    chk("clr_evt", {30'd0, evt_b}, 0);
    chk("clr_out", {31'd0, out_b}, 1);
    clr_b = 1'b0;
    in_b  = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
